// File: rtl/ah_pl2ddr_pkg.sv
// Shared types and constants for the PL-to-DDR command path.
// Holds the arbiter state encoding, the command word set and the
// command FSM state codes that the arbiter watches.
package ah_pl2ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACC  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HOLD      = 3'd5
    } arb_state_t;

    // Command words understood by the command FSM
    localparam logic [31:0] CMD_NOP = 32'h0000_0000;
    localparam logic [31:0] CMD_RST = 32'h0000_0001;
    localparam logic [31:0] CMD_WR  = 32'h0000_0002;
    localparam logic [31:0] CMD_RD  = 32'h0000_0003;

    // Command FSM state codes
    localparam logic [3:0] FSM_IDLE     = 4'd0;
    localparam logic [3:0] FSM_INTR_ACK = 4'd9;

endpackage

// File: rtl/ah_pl2ddr_rr_pick.sv
// Combinational winner selection for the command arbiter.
// A valid requester carrying a reset command wins outright (lowest index);
// otherwise requesters are scanned round-robin from last_winner+1.
module ah_pl2ddr_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] rst_match,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IW-1:0]      winner_idx
);

    logic [NUM_REQ-1:0] rst_req;
    logic [IW-1:0]      cand;

    assign rst_req = valid & rst_match;

    // Loops run from the far end so the last hit written is the nearest one.
    always_comb begin
        winner_idx = last_winner;
        winner_oh  = '0;
        cand       = '0;
        if (|rst_req) begin
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (rst_req[i]) winner_idx = IW'(i);
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = IW'((int'(last_winner) + k) % NUM_REQ);
                if (valid[cand]) winner_idx = cand;
            end
        end
        winner_oh[winner_idx] = |valid;
    end

endmodule

// File: rtl/ah_pl2ddr_cmd_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single command port of the
// PL-to-DDR command FSM. Issues one cmd_en pulse per grant, follows the FSM
// state code through accept and completion, then acks the owner.
// Optional watchdog: define AH_PL2DDR_CMDARB_TIMEOUT_EN.
module ah_pl2ddr_cmd_arbiter
    import ah_pl2ddr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     in_req_valid,
    input  logic [32*NUM_REQ-1:0]  in_req_cmd,
    output logic [NUM_REQ-1:0]     out_req_ack,
    output logic [NUM_REQ-1:0]     out_grant,
    output logic [31:0]            out_cmd_data,
    output logic                   out_cmd_en,
    input  logic [3:0]             in_fsm_state,
    output logic                   out_busy,
    output logic                   out_timeout,
    output logic [2:0]             out_arb_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    arb_state_t                    state, state_nxt;
    logic [NUM_REQ-1:0][31:0]      cmd_vec;
    logic [NUM_REQ-1:0]            rst_match;
    logic [NUM_REQ-1:0]            pick_oh;
    logic [IW-1:0]                 pick_idx;
    logic [IW-1:0]                 win_idx;
    logic [IW-1:0]                 last_winner;
    logic [31:0]                   cmd_lat;
    logic [HW-1:0]                 hold_cnt;
    logic                          sel_load;
    logic                          done;
    logic                          to_hit;

    assign cmd_vec       = in_req_cmd;
    assign out_arb_state = state;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rst_match
        assign rst_match[i] = (cmd_vec[i] == CMD_RST);
    end

    ah_pl2ddr_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .valid       (in_req_valid),
        .rst_match   (rst_match),
        .last_winner (last_winner),
        .winner_oh   (pick_oh),
        .winner_idx  (pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; done covers both normal completion and watchdog expiry
    always_comb begin
        state_nxt = state;
        sel_load  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:      if (|in_req_valid) begin
                              state_nxt = ST_GRANT;
                              sel_load  = 1'b1;
                          end
            ST_GRANT:     if (in_fsm_state == FSM_IDLE) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_ACC;
            ST_WAIT_ACC:  if (in_fsm_state == FSM_INTR_ACK) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (in_fsm_state == FSM_IDLE) done = 1'b1;
            ST_HOLD:      if (hold_cnt <= HW'(1)) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (to_hit) done = 1'b1;
        if (done) state_nxt = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
    end

    // Datapath and registered outputs, all timed off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cmd_en   <= 1'b0;
            out_cmd_data <= '0;
            out_grant    <= '0;
            out_req_ack  <= '0;
            out_busy     <= 1'b0;
            win_idx      <= '0;
            cmd_lat      <= '0;
            last_winner  <= IW'(NUM_REQ - 1);
            hold_cnt     <= '0;
        end else begin
            out_cmd_en  <= (state_nxt == ST_ISSUE);
            out_busy    <= (state_nxt != ST_IDLE);
            out_req_ack <= '0;
            if (sel_load) begin
                win_idx   <= pick_idx;
                cmd_lat   <= cmd_vec[pick_idx];
                out_grant <= pick_oh;
            end
            if (state_nxt == ST_ISSUE) out_cmd_data <= cmd_lat;
            if (done) begin
                out_req_ack <= out_grant;
                out_grant   <= '0;
                last_winner <= win_idx;
                hold_cnt    <= HW'(HOLDOFF);
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

`ifdef AH_PL2DDR_CMDARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          waiting;

    assign waiting = (state == ST_WAIT_ACC) || (state == ST_WAIT_DONE);
    assign to_hit  = waiting && (to_cnt == TW'(TIMEOUT - 1));

    // Watchdog counts cycles spent waiting on the FSM; flag is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            out_timeout <= 1'b0;
        end else begin
            to_cnt <= waiting ? to_cnt + TW'(1) : '0;
            if (to_hit) out_timeout <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ah_pl2ddr_cmd_arbiter.sv
// Directed bench for ah_pl2ddr_cmd_arbiter. The command FSM is modelled by
// driving in_fsm_state by hand. Timeout scenario runs only when
// AH_PL2DDR_CMDARB_TIMEOUT_EN is defined.
module tb_ah_pl2ddr_cmd_arbiter;
    import ah_pl2ddr_pkg::*;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   cmds;
    logic [32*N-1:0]      req_cmd;
    logic [N-1:0]         req_ack;
    logic [N-1:0]         grant;
    logic [31:0]          cmd_data;
    logic                 cmd_en;
    logic [3:0]           fsm_state;
    logic                 busy;
    logic                 timeout;
    logic [2:0]           arb_state;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_total [N] = '{default: 0};

    assign req_cmd = cmds;

    always #5 clk = ~clk;

    ah_pl2ddr_cmd_arbiter #(.NUM_REQ(N), .HOLDOFF(2), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_req_valid  (req_valid),
        .in_req_cmd    (req_cmd),
        .out_req_ack   (req_ack),
        .out_grant     (grant),
        .out_cmd_data  (cmd_data),
        .out_cmd_en    (cmd_en),
        .in_fsm_state  (fsm_state),
        .out_busy      (busy),
        .out_timeout   (timeout),
        .out_arb_state (arb_state)
    );

    // Tally ack pulses per requester
    always @(negedge clk)
        for (int i = 0; i < N; i++)
            if (req_ack[i]) ack_total[i] = ack_total[i] + 1;

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; cmds = '0; fsm_state = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for the issue strobe; cyc = -1 if it never comes
    task automatic wait_issue(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (cmd_en) begin cyc = k; break; end
        end
    endtask

    // FSM model after an issue: accept (9), work (1), return idle (0)
    task automatic fsm_accept();
        fsm_state = 4'd9;
        repeat (2) @(negedge clk);
        fsm_state = 4'd1;
        @(negedge clk);
        fsm_state = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; cmds = '0; fsm_state = 4'd0;
        @(negedge clk);
        n_cmp++;
        if ({cmd_en, cmd_data, grant, req_ack, busy, timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: en=%b data=%h grant=%b ack=%b busy=%b to=%b, all required 0",
                     cmd_en, cmd_data, grant, req_ack, busy, timeout);
        end
        n_cmp++;
        if (arb_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", arb_state); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, arb_state} !== 4'b0) begin
            n_bad++; $display("FAIL idle_no_req: busy=%b state=%0d want 0/0", busy, arb_state);
        end
    endtask

    task automatic test_single();
        cmds[1] = 32'h21; req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if ({grant, arb_state, cmd_en, busy} !== {4'b0010, 3'd1, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL single_grant: grant=%b state=%0d en=%b busy=%b want 0010/1/0/1",
                              grant, arb_state, cmd_en, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({cmd_en, cmd_data} !== {1'b1, 32'h21}) begin
            n_bad++; $display("FAIL single_issue: en=%b data=%h want 1/00000021", cmd_en, cmd_data);
        end
        fsm_state = 4'd9;
        @(negedge clk);
        n_cmp++;
        if ({cmd_en, arb_state} !== {1'b0, 3'd3}) begin
            n_bad++; $display("FAIL single_en_pulse: en=%b state=%0d want 0/3", cmd_en, arb_state);
        end
        @(negedge clk);
        fsm_state = 4'd1;
        n_cmp++;
        if (arb_state !== 3'd4) begin n_bad++; $display("FAIL single_wait_done: state=%0d want 4", arb_state); end
        @(negedge clk);
        fsm_state = 4'd0;
        n_cmp++;
        if (req_ack !== 4'b0) begin n_bad++; $display("FAIL single_early_ack: ack=%b want 0000", req_ack); end
        @(negedge clk);
        n_cmp++;
        if ({req_ack, grant, arb_state} !== {4'b0010, 4'b0000, 3'd5}) begin
            n_bad++; $display("FAIL single_ack: ack=%b grant=%b state=%0d want 0010/0000/5",
                              req_ack, grant, arb_state);
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if ({req_ack, arb_state} !== {4'b0, 3'd5}) begin
            n_bad++; $display("FAIL single_hold2: ack=%b state=%0d want 0000/5", req_ack, arb_state);
        end
        @(negedge clk);
        n_cmp++;
        if ({arb_state, busy, cmd_data} !== {3'd0, 1'b0, 32'h21}) begin
            n_bad++; $display("FAIL single_back_idle: state=%0d busy=%b data=%h want 0/0/00000021",
                              arb_state, busy, cmd_data);
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_oh  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] exp_dat [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0};
        int base [N];
        int cyc;
        do_reset();
        for (int i = 0; i < N; i++) base[i] = ack_total[i];
        cmds[0] = 32'hA0; cmds[1] = 32'hA1; cmds[2] = 32'hA2; cmds[3] = 32'hA3;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_issue(cyc);
            n_cmp++;
            if (cyc < 0 || grant !== exp_oh[n] || cmd_data !== exp_dat[n]) begin
                n_bad++; $display("FAIL fair_grant%0d: cyc=%0d grant=%b data=%h want grant=%b data=%h",
                                  n, cyc, grant, cmd_data, exp_oh[n], exp_dat[n]);
            end
            fsm_accept();
            n_cmp++;
            if (req_ack !== exp_oh[n]) begin
                n_bad++; $display("FAIL fair_ack%0d: ack=%b want %b", n, req_ack, exp_oh[n]);
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ack_total[0] - base[0] != 2 || ack_total[1] - base[1] != 1 ||
            ack_total[2] - base[2] != 1 || ack_total[3] - base[3] != 1) begin
            n_bad++; $display("FAIL fair_ack_count: %0d %0d %0d %0d want 2 1 1 1",
                              ack_total[0] - base[0], ack_total[1] - base[1],
                              ack_total[2] - base[2], ack_total[3] - base[3]);
        end
    endtask

    task automatic test_reset_priority();
        int cyc;
        do_reset();
        cmds[0] = 32'h100; cmds[2] = 32'h1; req_valid = 4'b0101;
        wait_issue(cyc);
        n_cmp++;
        if (cyc < 0 || grant !== 4'b0100 || cmd_data !== 32'h1) begin
            n_bad++; $display("FAIL prio_first: cyc=%0d grant=%b data=%h want 0100/00000001",
                              cyc, grant, cmd_data);
        end
        fsm_accept();
        req_valid[2] = 1'b0;
        wait_issue(cyc);
        n_cmp++;
        if (cyc < 0 || grant !== 4'b0001 || cmd_data !== 32'h100) begin
            n_bad++; $display("FAIL prio_second: cyc=%0d grant=%b data=%h want 0001/00000100",
                              cyc, grant, cmd_data);
        end
        fsm_accept();
        req_valid = '0;
        n_cmp++;
        if (req_ack !== 4'b0001) begin n_bad++; $display("FAIL prio_ack: ack=%b want 0001", req_ack); end
    endtask

    task automatic test_busy_fsm();
        repeat (3) @(negedge clk);
        fsm_state = 4'd6; cmds[1] = 32'h33; req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010) begin n_bad++; $display("FAIL busy_grant: grant=%b want 0010", grant); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({cmd_en, arb_state} !== {1'b0, 3'd1}) begin
                n_bad++; $display("FAIL busy_hold%0d: en=%b state=%0d want 0/1", k, cmd_en, arb_state);
            end
        end
        fsm_state = 4'd0;
        @(negedge clk);
        n_cmp++;
        if ({cmd_en, cmd_data} !== {1'b1, 32'h33}) begin
            n_bad++; $display("FAIL busy_issue: en=%b data=%h want 1/00000033", cmd_en, cmd_data);
        end
        fsm_accept();
        req_valid = '0;
        n_cmp++;
        if (req_ack !== 4'b0010) begin n_bad++; $display("FAIL busy_ack: ack=%b want 0010", req_ack); end
    endtask

    task automatic test_withdraw_and_reset();
        int cyc;
        int base0;
        repeat (3) @(negedge clk);
        cmds[3] = 32'h44; req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0; cmds[3] = 32'hDEAD;
        @(negedge clk);
        n_cmp++;
        if ({cmd_en, cmd_data} !== {1'b1, 32'h44}) begin
            n_bad++; $display("FAIL withdraw_issue: en=%b data=%h want 1/00000044", cmd_en, cmd_data);
        end
        fsm_accept();
        n_cmp++;
        if (req_ack !== 4'b1000) begin n_bad++; $display("FAIL withdraw_ack: ack=%b want 1000", req_ack); end
        repeat (3) @(negedge clk);
        base0 = ack_total[0];
        cmds[0] = 32'h55; req_valid = 4'b0001;
        wait_issue(cyc);
        fsm_state = 4'd9;
        repeat (2) @(negedge clk);
        fsm_state = 4'd1;
        @(negedge clk);
        n_cmp++;
        if (cyc < 0 || arb_state !== 3'd4) begin
            n_bad++; $display("FAIL midrst_setup: cyc=%0d state=%0d want state 4", cyc, arb_state);
        end
        rst_n = 1'b0; req_valid = '0;
        #1;
        n_cmp++;
        if ({cmd_en, cmd_data, grant, req_ack, busy, timeout, arb_state} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: en=%b data=%h grant=%b ack=%b busy=%b state=%0d, all required 0",
                              cmd_en, cmd_data, grant, req_ack, busy, arb_state);
        end
        fsm_state = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ack_total[0] != base0 || arb_state !== 3'd0) begin
            n_bad++; $display("FAIL midrst_no_ack: acks=%0d state=%0d want %0d/0",
                              ack_total[0], arb_state, base0);
        end
    endtask

`ifdef AH_PL2DDR_CMDARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int k_ack;
        logic prev_to;
        repeat (3) @(negedge clk);
        fsm_state = 4'd0; cmds[1] = 32'h77; req_valid = 4'b0010;
        wait_issue(cyc);
        k_ack = -1; prev_to = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            prev_to = timeout;
            @(negedge clk);
            if (req_ack != '0) begin k_ack = k; break; end
        end
        n_cmp++;
        if (cyc < 0 || k_ack != 17 || prev_to !== 1'b0) begin
            n_bad++; $display("FAIL to_latency: ack after %0d cycles (prev flag %b) want 17 (0)", k_ack, prev_to);
        end
        n_cmp++;
        if ({req_ack, timeout, arb_state} !== {4'b0010, 1'b1, 3'd5}) begin
            n_bad++; $display("FAIL to_ack: ack=%b to=%b state=%0d want 0010/1/5", req_ack, timeout, arb_state);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({timeout, arb_state} !== {1'b1, 3'd0}) begin
            n_bad++; $display("FAIL to_sticky: to=%b state=%0d want 1/0", timeout, arb_state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_reset_priority();
        test_busy_fsm();
        test_withdraw_and_reset();
`ifdef AH_PL2DDR_CMDARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end within 200000 time units");
        $fatal(1);
    end

endmodule
